// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined two's-complement adder/subtractor, carry chain split into STAGES chunks.
// Latency: STAGES cycles from accept to OUT valid; one beat per cycle throughput.
// Backpressure: global stall, in_ready = !out_valid || out_ready; every stage register freezes on stall.
//
// Parameters
//   WIDTH   operand/result width, must be a multiple of STAGES
//   STAGES  number of registered carry-chain chunks (1..WIDTH)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   a, b, sub, ci         operands, 0=add 1=subtract, carry-in / borrow-in
//   sat                   saturate request (only with PIPE_ADD_SAT_EN)
//   out_valid / out_ready result beat handshake
//   s, c, v               result, raw MSB carry-out, signed overflow
//
// Optional feature macro: PIPE_ADD_SAT_EN
//   defined   -> sat port exists and clamps s to the signed limit on overflow
//   undefined -> no sat port, s wraps modulo 2^WIDTH

module pipe_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
`ifdef PIPE_ADD_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Global pipeline advance: the whole pipe moves only when the output
    // register is empty or being drained this cycle.
    logic adv;

    // Inputs seen by each stage's combinational adder. Index 0 is fed from
    // the ports; index k>0 is the register bank written by stage k-1.
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_bx  [STAGES];
    logic [WIDTH-1:0] stg_sum [STAGES];
    logic             stg_cin [STAGES];
    logic             stg_vld [STAGES];
`ifdef PIPE_ADD_SAT_EN
    logic             stg_sat [STAGES];
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is A + ~B + ~CI, so a borrow-in of 1 becomes a carry-in of 0.
    assign stg_a[0]   = a;
    assign stg_bx[0]  = sub ? ~b : b;
    assign stg_sum[0] = '0;
    assign stg_cin[0] = sub ? ~ci : ci;
    assign stg_vld[0] = in_valid;
`ifdef PIPE_ADD_SAT_EN
    assign stg_sat[0] = sat;
`endif

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [CW-1:0]    chunk;
            logic             co;
            logic [WIDTH-1:0] sum_next;

            // One chunk of the carry chain, fed by the carry registered
            // by the previous stage.
            assign {co, chunk} = {1'b0, stg_a[k][k*CW +: CW]}
                               + {1'b0, stg_bx[k][k*CW +: CW]}
                               + {{CW{1'b0}}, stg_cin[k]};

            // Lower chunks arrive already summed (deskew); splice this
            // stage's chunk in so the full word travels together.
            always_comb begin
                sum_next             = stg_sum[k];
                sum_next[k*CW +: CW] = chunk;
            end

            if (k < LAST) begin : g_mid
                logic [WIDTH-1:0] a_r;
                logic [WIDTH-1:0] bx_r;
                logic [WIDTH-1:0] sum_r;
                logic             cy_r;
                logic             vld_r;
`ifdef PIPE_ADD_SAT_EN
                logic             sat_r;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_r   <= '0;
                        bx_r  <= '0;
                        sum_r <= '0;
                        cy_r  <= 1'b0;
                        vld_r <= 1'b0;
`ifdef PIPE_ADD_SAT_EN
                        sat_r <= 1'b0;
`endif
                    end else if (adv) begin
                        a_r   <= stg_a[k];
                        bx_r  <= stg_bx[k];
                        sum_r <= sum_next;
                        cy_r  <= co;
                        vld_r <= stg_vld[k];
`ifdef PIPE_ADD_SAT_EN
                        sat_r <= stg_sat[k];
`endif
                    end
                end

                assign stg_a[k+1]   = a_r;
                assign stg_bx[k+1]  = bx_r;
                assign stg_sum[k+1] = sum_r;
                assign stg_cin[k+1] = cy_r;
                assign stg_vld[k+1] = vld_r;
`ifdef PIPE_ADD_SAT_EN
                assign stg_sat[k+1] = sat_r;
`endif
            end else begin : g_last
                logic [WIDTH-1:0] s_next;
                logic             v_next;

                // Overflow: operands agree in sign but the result does not.
                // Uses the effective operand Bx, so it covers subtract too.
                assign v_next = (stg_a[k][WIDTH-1] == stg_bx[k][WIDTH-1])
                             && (sum_next[WIDTH-1] != stg_a[k][WIDTH-1]);

`ifdef PIPE_ADD_SAT_EN
                // On overflow the true result lies beyond the limit on the
                // side of A's sign; c and v keep the unsaturated values.
                always_comb begin
                    s_next = sum_next;
                    if (v_next && stg_sat[k]) begin
                        s_next = stg_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
                    end
                end
`else
                assign s_next = sum_next;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid <= 1'b0;
                        s         <= '0;
                        c         <= 1'b0;
                        v         <= 1'b0;
                    end else if (adv) begin
                        out_valid <= stg_vld[k];
                        s         <= s_next;
                        c         <= co;
                        v         <= v_next;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed + randomized check of pipe_add_sub (WIDTH=32, STAGES=4).
// Latency: expected output timing comes from a queue of in-flight beats with advance counts.
// Backpressure: out_ready is driven with fixed and random patterns; stalls must hold the output.

module tb_pipe_add_sub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
`ifdef PIPE_ADD_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        int          age;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub_in;
    logic             ci_in;
    logic             sat_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s_out;
    logic             c_out;
    logic             v_out;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic dmy;

    pipe_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .sub       (sub_in),
        .ci        (ci_in),
`ifdef PIPE_ADD_SAT_EN
        .sat       (sat_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s_out),
        .c         (c_out),
        .v         (v_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Arithmetic reference: plain signed/unsigned math on the operands.
    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi,
                                   input logic si, input logic cii, input logic sai);
        exp_t        e;
        longint      as_;
        longint      bs_;
        longint      r;
        logic [32:0] u;
        as_ = longint'($signed(ai));
        bs_ = longint'($signed(bi));
        r   = si ? (as_ - bs_ - longint'(cii)) : (as_ + bs_ + longint'(cii));
        e.s = r[31:0];
        e.v = (r > SMAX) || (r < SMIN);
        if (si) begin
            e.c = ({1'b0, ai} >= ({1'b0, bi} + 33'(cii)));
        end else begin
            u   = {1'b0, ai} + {1'b0, bi} + 33'(cii);
            e.c = u[32];
        end
        if (SAT_ON && sai && e.v) e.s = ai[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.age = 1;
        return e;
    endfunction

    // One clock: check outputs/handshake at the negedge against the queue,
    // then update the queue at the posedge. A beat is at the output once it
    // has seen STAGES advancing edges (its capture edge included).
    task automatic step(output logic acc);
        logic exp_ov;
        logic adv_m;
        logic cons;
        exp_t e;
        @(negedge clk);
        exp_ov = (q.size() > 0) && (q[0].age >= STAGES);
        adv_m  = !exp_ov || out_ready;
        cons   = exp_ov && out_ready;
        acc    = in_valid && adv_m;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(adv_m));
        if (exp_ov) begin
            chk("s", s_out, q[0].s);
            chk("c", 32'(c_out), 32'(q[0].c));
            chk("v", 32'(v_out), 32'(q[0].v));
        end
        @(posedge clk);
        if (cons) void'(q.pop_front());
        if (adv_m) foreach (q[i]) q[i].age = q[i].age + 1;
        if (acc) begin
            e = model(a_in, b_in, sub_in, ci_in, sat_in);
            q.push_back(e);
        end
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                            input logic si, input logic cii, input logic sai,
                            input logic [31:0] es, input logic ec, input logic ev);
        int   n;
        logic got;
        in_valid = 1'b1;
        a_in = ai; b_in = bi; sub_in = si; ci_in = cii; sat_in = sai;
        step(got);
        chk({tag, "_acc"}, 32'(got), 32'd1);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            step(dmy);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(STAGES));
        chk({tag, "_s"}, s_out, es);
        chk({tag, "_c"}, 32'(c_out), 32'(ec));
        chk({tag, "_v"}, 32'(v_out), 32'(ev));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int i;
        int p;
        int budget;
        logic got;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; sub_in = 1'b0; ci_in = 1'b0; sat_in = 1'b0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", s_out, 32'd0);
        chk("rst_c", 32'(c_out), 32'd0);
        chk("rst_v", 32'(v_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step(dmy);

        // Directed vectors
        directed("carry", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("borrow", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0);
        directed("ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("ovf_sat", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1,
                 SAT_ON ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_sat", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1,
                 SAT_ON ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("sub_plain", 32'd10, 32'd3, 1'b1, 1'b0, 1'b0, 32'd7, 1'b1, 1'b0);
        directed("add_ci", 32'h0000_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(dmy);

        // Backpressure: 10 beats A=B=i, out_ready pattern 1,0,0 repeating
        i = 0; p = 0; budget = 0;
        sub_in = 1'b0; ci_in = 1'b0; sat_in = 1'b0;
        while (i < 10 && budget < 200) begin
            in_valid  = 1'b1;
            a_in      = 32'(i);
            b_in      = 32'(i);
            out_ready = (p % 3 == 0);
            step(got);
            if (got) i++;
            p++;
            budget++;
        end
        chk("bp_sent", 32'(i), 32'd10);
        in_valid = 1'b0;
        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            out_ready = (p % 3 == 0);
            step(dmy);
            p++;
            budget++;
        end
        chk("bp_drained", 32'(q.size()), 32'd0);
        out_ready = 1'b1;
        step(dmy);

        // Bubbles: valid on alternate cycles
        for (int n = 0; n < 16; n++) begin
            in_valid = (n % 2 == 0) && (n < 10);
            a_in = 32'h100 + 32'(n); b_in = 32'h3 * 32'(n);
            step(dmy);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a_in   = pick();
            b_in   = pick();
            sub_in = $urandom_range(0, 1) == 1;
            ci_in  = $urandom_range(0, 1) == 1;
            sat_in = $urandom_range(0, 1) == 1;
            step(dmy);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) step(dmy);
        chk("rand_drained", 32'(q.size()), 32'd0);

        // Reset mid-flight
        sub_in = 1'b0; ci_in = 1'b0; sat_in = 1'b0;
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1;
            a_in = 32'h1111_0000 + 32'(n);
            b_in = 32'h0101_0101;
            step(dmy);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_s", s_out, 32'd0);
        chk("mid_rst_c", 32'(c_out), 32'd0);
        chk("mid_rst_v", 32'(v_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) step(dmy);
        directed("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0,
                 32'h0000_0100, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(dmy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
